// File: rtl/system2_pkg.sv
// -----------------------------------------------------------------------------
// system2_pkg
// Shared definitions for the System 2 datapath controller:
//   - state_t          : controller FSM states
//   - W_DEFAULT        : default operand/result width
//   - DP_LAT_DEFAULT   : default datapath load-to-output latency (cycles)
// -----------------------------------------------------------------------------
package system2_pkg;

    localparam int W_DEFAULT      = 8;
    localparam int DP_LAT_DEFAULT = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/system2_wait_cnt.sv
// -----------------------------------------------------------------------------
// system2_wait_cnt
// Loadable down-counter with zero flag, used to time the datapath latency.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset (count -> 0)
//   load     in   load count from load_val (has priority over dec)
//   dec      in   decrement by one (saturates at zero)
//   load_val in   value loaded when load=1
//   zero     out  count == 0
// -----------------------------------------------------------------------------
module system2_wait_cnt
    import system2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/system2_ctrl.sv
// -----------------------------------------------------------------------------
// system2_ctrl
// Controller stage in front of the System 2 datapath. Accepts one operand pair
// per start (sampled only in IDLE), sequences the datapath clr/ld strobes,
// waits DP_LAT cycles, then captures the datapath outputs and pulses done.
//
// Build option: define SYS2_OPCOUNT_EN to enable the 16-bit completed-operation
// counter on op_count; otherwise op_count is tied to zero (same port list).
//
// Parameters: W (data width), DP_LAT (datapath latency, >=1),
//             CLR_EACH_OP (1: CLEAR cycle before every LOAD, 0: skip it)
// Ports:
//   clk, reset                  clock / synchronous active-high reset
//   start, a_in, b_in           request and operands (captured on accept)
//   dp_a, dp_b, dp_ld, dp_clr   drive the datapath
//   dp_out_a/b/c                datapath results
//   res_a/b/c                   captured results, held until next capture
//   busy                        high in CLEAR, LOAD, WAIT
//   done                        one-cycle pulse in DONE
//   op_count                    completed-operation count
// -----------------------------------------------------------------------------
module system2_ctrl
    import system2_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int DP_LAT      = DP_LAT_DEFAULT,
    parameter int CLR_EACH_OP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic         dp_ld,
    output logic         dp_clr,
    input  logic [W-1:0] dp_out_a,
    input  logic [W-1:0] dp_out_b,
    input  logic [W-1:0] dp_out_c,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b,
    output logic [W-1:0] res_c,
    output logic         busy,
    output logic         done,
    output logic [15:0]  op_count
);

    localparam int CW = $clog2(DP_LAT + 1);

    state_t       state_q, state_d;
    logic [W-1:0] op_a_q, op_b_q;
    logic [W-1:0] res_a_q, res_b_q, res_c_q;
    logic         cnt_load, cnt_dec, cnt_zero;

    system2_wait_cnt #(
        .WIDTH (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CW'(DP_LAT - 1)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
        end else begin
            state_q <= state_d;
            // Operands are only replaced on accept, so dp_a/dp_b stay stable
            // for the whole operation and afterwards.
            if ((state_q == IDLE) && start) begin
                op_a_q <= a_in;
                op_b_q <= b_in;
            end
            if ((state_q == WAIT) && cnt_zero) begin
                res_a_q <= dp_out_a;
                res_b_q <= dp_out_b;
                res_c_q <= dp_out_c;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dp_ld    = 1'b0;
        dp_clr   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (CLR_EACH_OP != 0) ? CLEAR : LOAD;
                end
            end
            CLEAR: begin
                dp_clr  = 1'b1;
                busy    = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                dp_ld    = 1'b1;
                busy     = 1'b1;
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dp_a  = op_a_q;
    assign dp_b  = op_b_q;
    assign res_a = res_a_q;
    assign res_b = res_b_q;
    assign res_c = res_c_q;

`ifdef SYS2_OPCOUNT_EN
    logic [15:0] op_count_q;

    // Wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else if (state_q == DONE) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_system2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_system2_ctrl
// Two controller instances (CLR_EACH_OP=1 and CLR_EACH_OP=0), each driving a
// stub datapath (DP_LAT=1: ld registers A, B, A+B; clr zeroes them).
// Expected results are queued when an operation is issued and compared when
// the instance pulses done.
// -----------------------------------------------------------------------------
module tb_system2_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, start1;
    logic [7:0]  a0, b0, a1, b1;
    logic [7:0]  dpa0, dpb0, dpa1, dpb1;
    logic        ld0, clr0, ld1, clr1;
    logic [7:0]  oa0, ob0, oc0, oa1, ob1, oc1;
    logic [7:0]  ra0, rb0, rc0, ra1, rb1, rc1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] cnt0, cnt1;

    system2_ctrl #(.W(8), .DP_LAT(1), .CLR_EACH_OP(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0),
        .dp_a(dpa0), .dp_b(dpb0), .dp_ld(ld0), .dp_clr(clr0),
        .dp_out_a(oa0), .dp_out_b(ob0), .dp_out_c(oc0),
        .res_a(ra0), .res_b(rb0), .res_c(rc0),
        .busy(busy0), .done(done0), .op_count(cnt0)
    );

    system2_ctrl #(.W(8), .DP_LAT(1), .CLR_EACH_OP(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
        .dp_a(dpa1), .dp_b(dpb1), .dp_ld(ld1), .dp_clr(clr1),
        .dp_out_a(oa1), .dp_out_b(ob1), .dp_out_c(oc1),
        .res_a(ra1), .res_b(rb1), .res_c(rc1),
        .busy(busy1), .done(done1), .op_count(cnt1)
    );

    // Stub datapaths
    always_ff @(posedge clk) begin
        if (clr0) begin
            oa0 <= 8'h00; ob0 <= 8'h00; oc0 <= 8'h00;
        end else if (ld0) begin
            oa0 <= dpa0; ob0 <= dpb0; oc0 <= dpa0 + dpb0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr1) begin
            oa1 <= 8'h00; ob1 <= 8'h00; oc1 <= 8'h00;
        end else if (ld1) begin
            oa1 <= dpa1; ob1 <= dpb1; oc1 <= dpa1 + dpb1;
        end
    end

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: compare held results on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("res_a0", 32'(ra0), 32'(e.a));
                chk("res_b0", 32'(rb0), 32'(e.b));
                chk("res_c0", 32'(rc0), 32'(e.c));
                $display("dut0 done: a=%02h b=%02h c=%02h", ra0, rb0, rc0);
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("res_a1", 32'(ra1), 32'(e.a));
                chk("res_b1", 32'(rb1), 32'(e.b));
                chk("res_c1", 32'(rc1), 32'(e.c));
                $display("dut1 done: a=%02h b=%02h c=%02h", ra1, rb1, rc1);
            end
        end
    end

    // Issue one operation and check strobe timing relative to acceptance.
    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
        exp_t e;
        int clr_k, ld_k, done_k;
        logic [7:0] ld_a, ld_b;
        clr_k = -1; ld_k = -1; done_k = -1;
        ld_a = 8'h00; ld_b = 8'h00;
        e.a = a; e.b = b; e.c = c;
        @(negedge clk);
        if (sel == 1'b0) begin
            start0 = 1'b1; a0 = a; b0 = b; q0.push_back(e);
        end else begin
            start1 = 1'b1; a1 = a; b1 = b; q1.push_back(e);
        end
        for (int k = 1; k <= 12 && done_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin start0 = 1'b0; start1 = 1'b0; end
            if (sel == 1'b0) begin
                if (clr0 && clr_k < 0) clr_k = k;
                if (ld0 && ld_k < 0) begin ld_k = k; ld_a = dpa0; ld_b = dpb0; end
                if (done0) done_k = k;
            end else begin
                if (clr1 && clr_k < 0) clr_k = k;
                if (ld1 && ld_k < 0) begin ld_k = k; ld_a = dpa1; ld_b = dpb1; end
                if (done1) done_k = k;
            end
        end
        chk("clr_cycle",  32'(clr_k),  sel ? 32'hFFFF_FFFF : 32'd1);
        chk("ld_cycle",   32'(ld_k),   sel ? 32'd1 : 32'd2);
        chk("done_cycle", 32'(done_k), sel ? 32'd3 : 32'd4);
        chk("dp_a_at_ld", 32'(ld_a), 32'(a));
        chk("dp_b_at_ld", 32'(ld_b), 32'(b));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld_n, done_n;
        exp_t e;

        vecs[0] = '{1'b0, 8'd9,  8'd2,  8'd11};
        vecs[1] = '{1'b1, 8'hF5, 8'h04, 8'hF9};
        vecs[2] = '{1'b1, 8'hEB, 8'hFB, 8'hE6};
        vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00};
        vecs[4] = '{1'b0, 8'hAA, 8'h55, 8'hFF};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        // Idle after reset with start low
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_busy0", 32'(busy0), 32'd0);
            chk("rst_done0", 32'(done0), 32'd0);
            chk("rst_strobes0", 32'({ld0, clr0}), 32'd0);
            chk("rst_busy1", 32'(busy1), 32'd0);
        end
        chk("rst_dp0", 32'({dpa0, dpb0}), 32'd0);
        chk("rst_res0", 32'({ra0, rb0, rc0}), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c);
            $display("vec %0d issued on dut%0d: a=%02h b=%02h", i, vecs[i].sel, vecs[i].a, vecs[i].b);
        end

`ifndef SYS2_OPCOUNT_EN
        chk("opcount0_tied", 32'(cnt0), 32'd0);
        chk("opcount1_tied", 32'(cnt1), 32'd0);
`endif

        // start held high: one op per 5 cycles, no extra loads
        e.a = 8'h3C; e.b = 8'h11; e.c = 8'h4D;
        @(negedge clk);
        start0 = 1'b1; a0 = 8'h3C; b0 = 8'h11;
        for (int i = 0; i < 4; i++) q0.push_back(e);
        ld_n = 0; done_n = 0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (ld0) ld_n++;
            if (done0) done_n++;
            if (k == 20) start0 = 1'b0;
        end
        chk("cont_loads", 32'(ld_n), 32'd4);
        chk("cont_dones", 32'(done_n), 32'd4);
        $display("continuous start: loads=%0d dones=%0d", ld_n, done_n);

        // Reset during WAIT abandons the operation
        @(negedge clk);
        start0 = 1'b1; a0 = 8'h77; b0 = 8'h01;
        @(negedge clk); start0 = 1'b0;   // CLEAR
        @(negedge clk);                  // LOAD
        @(negedge clk);                  // WAIT
        chk("wait_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_done", 32'(done0), 32'd0);
        chk("rstmid_busy", 32'(busy0), 32'd0);
        chk("rstmid_strobes", 32'({ld0, clr0}), 32'd0);
        chk("rstmid_dp", 32'({dpa0, dpb0}), 32'd0);
        chk("rstmid_res", 32'({ra0, rb0, rc0}), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_no_done", 32'(done0), 32'd0);
        end
        run_op(1'b0, 8'h12, 8'h34, 8'h46);
        $display("fresh op after mid-operation reset issued");

`ifdef SYS2_OPCOUNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, 8'h01, 8'h02, 8'h03);
        run_op(1'b0, 8'h04, 8'h05, 8'h09);
        run_op(1'b0, 8'h06, 8'h07, 8'h0D);
        chk("opcount_three", 32'(cnt0), 32'd3);
        force dut0.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut0.op_count_q;
        run_op(1'b0, 8'h10, 8'h20, 8'h30);
        chk("opcount_wrap", 32'(cnt0), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
